alu_control_mdu: RTL
====================

ALU_CONTROL_MDU -- requirements
Module: alu_control_mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width; legal values 8..64.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ALUOp  input  2  main-control ALU operation class.
REQ-006 instruction  input  6  R-type funct field.
REQ-007 start  input  1  request to launch a multiply/divide; sampled each clk.
REQ-008 op_a  input  WIDTH  rs operand (multiplicand/dividend).
REQ-009 op_b  input  WIDTH  rt operand (multiplier/divisor).
REQ-010 ALU_control  output  4  ALU function code, combinational.
REQ-011 busy  output  1  multiply/divide in progress.
REQ-012 done  output  1  one-cycle pulse when HI/LO are updated.
REQ-013 stall  output  1  pipeline hold request.
REQ-014 hi  output  WIDTH  HI register.
REQ-015 lo  output  WIDTH  LO register.

Function
REQ-016 ALU_control SHALL be combinational, with these encodings: ALUOp 00 -> 1000; 01 -> 0110; 11 -> 1111.
REQ-017 With ALUOp 10, ALU_control SHALL decode instruction as: 100100 -> 0000; 100101 -> 0001; 100000 -> 0010; 100010 -> 0110; 101010 -> 0111; 100111 (nor) -> 1100; 010000 (mfhi) -> 1010; 010010 (mflo) -> 1011; any other value -> 1111.
REQ-018 ALU_control SHALL never be X; 1111 is the defined "no ALU op" code.
REQ-019 An MDU op SHALL be ALUOp=10 with instruction 011001 (multu) or 011011 (divu); both are unsigned, and ALU_control SHALL read 1111 for both.
REQ-020 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-021 In IDLE, start with an MDU op SHALL latch op_a and op_b and move to MUL or DIV.
REQ-022 In IDLE, start with a non-MDU op SHALL be ignored.
REQ-023 MUL and DIV SHALL each run exactly WIDTH cycles, one bit per cycle: shift-add for MUL, restoring division for DIV. The FSM then SHALL enter DONE.
REQ-024 DONE SHALL last one cycle; it SHALL assert done and write hi/lo, then return to IDLE.
REQ-025 Total latency from the start sample to the done pulse SHALL be WIDTH+1 cycles.
REQ-026 multu SHALL produce the 2*WIDTH-bit product {hi,lo}, with no truncation.
REQ-027 divu SHALL write lo=quotient and hi=remainder.
REQ-028 divu with op_b=0 SHALL skip iteration, going IDLE -> DONE in the next cycle with lo = all ones and hi = op_a.
REQ-029 busy SHALL be high in MUL and DIV only.
REQ-030 start SHALL be ignored in MUL, DIV and DONE, with no queueing.
REQ-031 stall SHALL equal busy OR (ALUOp=10 AND instruction is mfhi/mflo/multu/divu AND state is not IDLE).
REQ-032 hi and lo SHALL change only in DONE and on reset; they hold their values otherwise.
REQ-033 An MDU op and mfhi/mflo in the same cycle: the MDU op SHALL take priority.

Reset
REQ-034 reset SHALL force state=IDLE and hi=lo=0, and clear busy=done=stall=0 and all internal working registers, independent of clk.
REQ-035 reset mid-operation SHALL abort with no done pulse.
REQ-036 The first start accepted after reset deassertion SHALL behave per REQ-021.

Structure
REQ-037 Package alu_ctrl_pkg SHALL hold the 4-bit ALU_control code constants, the funct constants and the FSM state enumeration.
REQ-038 The iterative multiply/divide datapath SHALL be a single sub-module, mdu_iter (parameter WIDTH), containing the shift registers, adder/subtractor and iteration counter.
REQ-039 alu_control_mdu SHALL contain the decode logic and the FSM.

Verification (WIDTH=32)
REQ-040 Decode sweep: all ALUOp values x all 64 funct values -> ALU_control matches REQ-016..019, never X.
REQ-041 multu: start with op_a=op_b=FFFFFFFF -> busy for 32 cycles; done at cycle 33; hi=FFFFFFFE, lo=00000001.
REQ-042 divu: op_a=100, op_b=7 -> lo=14, hi=2 after 33 cycles; stall high while busy.
REQ-043 divu by zero: op_a=0000ABCD, op_b=0 -> done on the 2nd cycle; lo=FFFFFFFF, hi=0000ABCD.
REQ-044 Busy start: a second multu start at cycle 5 of a divu -> ignored; only the divu result is written; exactly one done pulse.
REQ-045 Reset mid-op: reset at cycle 10 of a multu -> state=IDLE, hi=lo=0, no done pulse; a new multu 3*5 then gives lo=15, hi=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decoder and the multiply/divide unit:
// ALU function codes, ALUOp classes, R-type funct values and FSM states.
package alu_ctrl_pkg;

  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned ALUOP_W    = 2;
  localparam int unsigned FUNCT_W    = 6;

  // ALU function codes driven on ALU_control
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_MEM  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_MFHI = 4'b1010;
  localparam logic [ALU_CTRL_W-1:0] ALU_MFLO = 4'b1011;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 4'b1100;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOP  = 4'b1111;

  // ALUOp classes from main control
  localparam logic [ALUOP_W-1:0] ALUOP_MEM   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BR    = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_NONE  = 2'b11;

  // R-type funct field values
  localparam logic [FUNCT_W-1:0] FUNCT_AND   = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR    = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD   = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB   = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT   = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR   = 6'b100111;
  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True for the funct values that read or write HI/LO
  function automatic logic uses_hilo(input logic [FUNCT_W-1:0] funct);
    return (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO) ||
           (funct == FUNCT_MULTU) || (funct == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide datapath, one result bit per step.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture a/b and clear the working state
//   step            : perform one iteration (mode chosen by div_mode)
//   div_mode        : 1 = restoring division, 0 = shift-add multiply
//   a, b            : multiplicand/dividend, multiplier/divisor
//   last_c          : current step is the final one
//   res_hi_c/lo_c   : working registers as they will be after this step;
//                     on the last step these are {hi,lo} of the result
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] res_hi_c,
  output logic [WIDTH-1:0] res_lo_c
);

  localparam int unsigned SW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  // upper: partial product high half / partial remainder
  // lower: multiplier being shifted out / dividend shifting into quotient
  logic [WIDTH-1:0] upper_q, upper_d;
  logic [WIDTH-1:0] lower_q, lower_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   x_c;
  logic [WIDTH:0]   acc_c;
  logic [SW-1:0]    sum_c;
  logic             no_borrow_c;
  logic [WIDTH-1:0] upper_nxt_c;
  logic [WIDTH-1:0] lower_nxt_c;

  // Single shared adder: add for multiply, subtract (two's complement) for divide
  always_comb begin
    x_c         = div_mode ? {upper_q, lower_q[WIDTH-1]} : {1'b0, upper_q};
    sum_c       = {1'b0, x_c} + ({2'b00, operand_q} ^ {SW{div_mode}}) + SW'(div_mode);
    no_borrow_c = ~sum_c[SW-1];
    acc_c       = lower_q[0] ? sum_c[WIDTH:0] : {1'b0, upper_q};
    if (div_mode) begin
      // Restore by keeping the shifted remainder when the subtract borrowed
      upper_nxt_c = no_borrow_c ? sum_c[WIDTH-1:0] : x_c[WIDTH-1:0];
      lower_nxt_c = {lower_q[WIDTH-2:0], no_borrow_c};
    end else begin
      upper_nxt_c = acc_c[WIDTH:1];
      lower_nxt_c = {acc_c[0], lower_q[WIDTH-1:1]};
    end
  end

  // Working-register next state
  always_comb begin
    upper_d   = upper_q;
    lower_d   = lower_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    if (load) begin
      upper_d   = '0;
      lower_d   = a;
      operand_d = b;
      cnt_d     = '0;
    end else if (step) begin
      upper_d = upper_nxt_c;
      lower_d = lower_nxt_c;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upper_q   <= '0;
      lower_q   <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
    end else begin
      upper_q   <= upper_d;
      lower_q   <= lower_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
    end
  end

  assign last_c   = (cnt_q == CW'(WIDTH - 1));
  assign res_hi_c = upper_nxt_c;
  assign res_lo_c = lower_nxt_c;

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decoder plus sequencer for an iterative multu/divu unit
// owning the HI/LO registers.
//   clk, reset      : clock, asynchronous active-high reset
//   ALUOp           : main-control operation class
//   instruction     : R-type funct field
//   start           : launch request for multu/divu
//   op_a, op_b      : rs / rt operands
//   ALU_control     : combinational ALU function code (1111 = no ALU op)
//   busy            : iteration in progress
//   done            : one-cycle pulse, HI/LO hold the new result
//   stall           : pipeline hold request (combinational)
//   hi, lo          : HI / LO registers
module alu_control_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ALUOP_W-1:0]    ALUOp,
  input  logic [FUNCT_W-1:0]    instruction,
  input  logic                  start,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  output logic [ALU_CTRL_W-1:0] ALU_control,
  output logic                  busy,
  output logic                  done,
  output logic                  stall,
  output logic [WIDTH-1:0]      hi,
  output logic [WIDTH-1:0]      lo
);

  state_e state_q, state_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             rtype_c;
  logic             is_multu_c;
  logic             is_divu_c;
  logic             accept_c;
  logic             div_zero_c;
  logic             mdu_load_c;
  logic             mdu_step_c;
  logic             mdu_last_c;
  logic [WIDTH-1:0] mdu_hi_c;
  logic [WIDTH-1:0] mdu_lo_c;

  // ALU function decode; every path ends in a defined code
  always_comb begin
    ALU_control = ALU_NOP;
    unique case (ALUOp)
      ALUOP_MEM:  ALU_control = ALU_MEM;
      ALUOP_BR:   ALU_control = ALU_SUB;
      ALUOP_NONE: ALU_control = ALU_NOP;
      ALUOP_RTYPE: begin
        unique case (instruction)
          FUNCT_AND:  ALU_control = ALU_AND;
          FUNCT_OR:   ALU_control = ALU_OR;
          FUNCT_ADD:  ALU_control = ALU_ADD;
          FUNCT_SUB:  ALU_control = ALU_SUB;
          FUNCT_SLT:  ALU_control = ALU_SLT;
          FUNCT_NOR:  ALU_control = ALU_NOR;
          FUNCT_MFHI: ALU_control = ALU_MFHI;
          FUNCT_MFLO: ALU_control = ALU_MFLO;
          default:    ALU_control = ALU_NOP;
        endcase
      end
      default: ALU_control = ALU_NOP;
    endcase
  end

  assign rtype_c    = (ALUOp == ALUOP_RTYPE);
  assign is_multu_c = rtype_c && (instruction == FUNCT_MULTU);
  assign is_divu_c  = rtype_c && (instruction == FUNCT_DIVU);
  assign accept_c   = (state_q == ST_IDLE) && start && (is_multu_c || is_divu_c);
  assign div_zero_c = is_divu_c && (op_b == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; divide by zero bypasses the iteration entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (is_multu_c)      state_d = ST_MUL;
          else if (div_zero_c) state_d = ST_DONE;
          else                 state_d = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (mdu_last_c) state_d = ST_DONE;
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // Output / datapath control; HI/LO load as the FSM enters DONE so they
  // are valid in the same cycle as the done pulse
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    mdu_load_c = 1'b0;
    mdu_step_c = 1'b0;
    busy_d     = (state_d == ST_MUL) || (state_d == ST_DIV);
    done_d     = (state_d == ST_DONE);
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (div_zero_c) begin
            hi_d = op_a;
            lo_d = '1;
          end else begin
            mdu_load_c = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        mdu_step_c = 1'b1;
        if (mdu_last_c) begin
          hi_d = mdu_hi_c;
          lo_d = mdu_lo_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu_iter (
    .clk      (clk),
    .rst      (reset),
    .load     (mdu_load_c),
    .step     (mdu_step_c),
    .div_mode (state_q == ST_DIV),
    .a        (op_a),
    .b        (op_b),
    .last_c   (mdu_last_c),
    .res_hi_c (mdu_hi_c),
    .res_lo_c (mdu_lo_c)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  // HI/LO consumers must also wait out the DONE cycle
  assign stall = busy_q || (rtype_c && uses_hilo(instruction) && (state_q != ST_IDLE));

endmodule
